// File: rtl/usb_tx_scheduler.sv
// Transmit scheduler: arbitrates packet requesters onto the single CRC5/bit-stuff pipeline.
// Optional macro TX_SCHED_STRICT_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module usb_tx_scheduler #(
   parameter int unsigned NUM_REQ  = 3,
   parameter int unsigned PKT_W    = 100,
   parameter int unsigned IPG      = 4,
   parameter int unsigned START_TO = 16
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*PKT_W-1:0]   req_pkt,
   input  logic [NUM_REQ*32-1:0]      req_len,
   input  logic                       tx_busy,
   output logic [NUM_REQ-1:0]         req_ack,
   output logic [NUM_REQ-1:0]         req_done,
   output logic [NUM_REQ-1:0]         req_err,
   output logic                       pkt_ready,
   output logic [PKT_W-1:0]           pkt_in,
   output logic [31:0]                pkt_len,
   output logic                       sched_busy
);

   localparam int unsigned IdxW   = $clog2(NUM_REQ);
   localparam int unsigned TimerW = $clog2(START_TO);
   localparam int unsigned GapW   = (IPG > 1) ? $clog2(IPG) : 1;

   typedef enum logic [2:0] {StIdle, StLoad, StWaitStart, StSending, StGap} state_e;

   state_e              state_q, state_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [PKT_W-1:0]    pkt_q, pkt_d;
   logic [31:0]         len_q, len_d;
   logic [TimerW-1:0]   timer_q, timer_d;
   logic [GapW-1:0]     gap_q, gap_d;

   logic                grant_found;
   logic [IdxW-1:0]     grant_idx;
   logic                len_ok;
   logic [NUM_REQ-1:0]  idx_oh;

   assign len_ok = (len_q >= 32'd8) && (len_q <= 32'(PKT_W));
   assign idx_oh = NUM_REQ'(1) << idx_q;

`ifdef TX_SCHED_STRICT_PRIO_EN
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            grant_found = 1'b1;
            grant_idx   = IdxW'(i);
         end
      end
   end
`else
   logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;

   // Scan offsets downward so the smallest offset from rr_ptr wins.
   always_comb begin
      int unsigned cand;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         cand = (int'(rr_ptr_q) + off) % NUM_REQ;
         if (req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = IdxW'(cand);
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (state_q == StIdle && grant_found) begin
         rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) rr_ptr_q <= '0;
      else          rr_ptr_q <= rr_ptr_d;
   end
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         pkt_q   <= '0;
         len_q   <= '0;
         timer_q <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pkt_q   <= pkt_d;
         len_q   <= len_d;
         timer_q <= timer_d;
         gap_q   <= gap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pkt_d   = pkt_q;
      len_d   = len_q;
      timer_d = timer_q;
      gap_d   = gap_q;
      case (state_q)
         StIdle: begin
            if (grant_found) begin
               idx_d   = grant_idx;
               pkt_d   = req_pkt[int'(grant_idx) * PKT_W +: PKT_W];
               len_d   = req_len[int'(grant_idx) * 32 +: 32];
               state_d = StLoad;
            end
         end
         StLoad: begin
            timer_d = '0;
            gap_d   = '0;
            state_d = len_ok ? StWaitStart : StGap;
         end
         StWaitStart: begin
            if (tx_busy) begin
               state_d = StSending;
            end else if (timer_q == TimerW'(START_TO - 1)) begin
               gap_d   = '0;
               state_d = StGap;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StSending: begin
            if (!tx_busy) begin
               gap_d   = '0;
               state_d = StGap;
            end
         end
         StGap: begin
            if (gap_q == GapW'(IPG - 1)) state_d = StIdle;
            else                         gap_d   = gap_q + 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ack    = '0;
      req_done   = '0;
      req_err    = '0;
      pkt_ready  = 1'b0;
      pkt_in     = pkt_q;
      pkt_len    = len_q;
      sched_busy = (state_q != StIdle);
      case (state_q)
         StLoad: begin
            req_ack = idx_oh;
            if (len_ok) pkt_ready = 1'b1;
            else        req_err   = idx_oh;
         end
         StWaitStart: begin
            if (!tx_busy && timer_q == TimerW'(START_TO - 1)) req_err = idx_oh;
         end
         StSending: begin
            if (!tx_busy) req_done = idx_oh;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Randomised scoreboard bench for usb_tx_scheduler: expected pulses are queued with the cycle
// they must appear in, and a negedge monitor matches every observed pulse against the queue.
module tb_usb_tx_scheduler;

   localparam int NR  = 3;
   localparam int PW  = 100;
   localparam int IPG = 4;
   localparam int STO = 16;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic [NR-1:0]     req_valid = '0;
   logic [NR*PW-1:0]  req_pkt = '0;
   logic [NR*32-1:0]  req_len = '0;
   logic              tx_busy = 1'b0;
   logic [NR-1:0]     req_ack, req_done, req_err;
   logic              pkt_ready;
   logic [PW-1:0]     pkt_in;
   logic [31:0]       pkt_len;
   logic              sched_busy;

   usb_tx_scheduler #(.NUM_REQ(NR), .PKT_W(PW), .IPG(IPG), .START_TO(STO)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_pkt    (req_pkt),
      .req_len    (req_len),
      .tx_busy    (tx_busy),
      .req_ack    (req_ack),
      .req_done   (req_done),
      .req_err    (req_err),
      .pkt_ready  (pkt_ready),
      .pkt_in     (pkt_in),
      .pkt_len    (pkt_len),
      .sched_busy (sched_busy)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int            cyc;
      logic [NR-1:0] ack;
      logic [NR-1:0] done;
      logic [NR-1:0] err;
      logic          rdy;
      logic [PW-1:0] pkt;
      logic [31:0]   len;
   } ev_t;

   ev_t exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   logic [PW-1:0] pk[NR];
   logic [31:0]   ln[NR];
   int            rr_m = 0;

   // Monitor: every pulse must match the head of the expectation queue.
   always @(negedge clock) begin
      if (reset_n && ((|req_ack) || (|req_done) || (|req_err) || pkt_ready)) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pulse cyc=%0d ack=%b done=%b err=%b rdy=%b, required none",
                     cyc, req_ack, req_done, req_err, pkt_ready);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.ack !== req_ack || e.done !== req_done || e.err !== req_err ||
                e.rdy !== pkt_ready || e.pkt !== pkt_in || e.len !== pkt_len) begin
               n_bad++;
               $display("FAIL pulse got cyc=%0d ack=%b done=%b err=%b rdy=%b len=%0d pkt=%h",
                        cyc, req_ack, req_done, req_err, pkt_ready, pkt_len, pkt_in);
               $display("     required cyc=%0d ack=%b done=%b err=%b rdy=%b len=%0d pkt=%h",
                        e.cyc, e.ack, e.done, e.err, e.rdy, e.len, e.pkt);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s got=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference arbitration: round-robin from rr_m, or lowest index under strict priority.
   function automatic int pick(input logic [NR-1:0] v);
`ifdef TX_SCHED_STRICT_PRIO_EN
      for (int i = 0; i < NR; i++) if (v[i]) return i;
`else
      for (int off = 0; off < NR; off++) if (v[(rr_m + off) % NR]) return (rr_m + off) % NR;
`endif
      return -1;
   endfunction

   function automatic ev_t mk(input int c, input int w, input bit a, input bit d, input bit er,
                              input bit r);
      ev_t e;
      logic [NR-1:0] oh;
      oh     = NR'(1) << w;
      e.cyc  = c;
      e.ack  = a  ? oh : '0;
      e.done = d  ? oh : '0;
      e.err  = er ? oh : '0;
      e.rdy  = r;
      e.pkt  = pk[w];
      e.len  = ln[w];
      return e;
   endfunction

   task automatic drive_reqs(input logic [NR-1:0] v);
      for (int i = 0; i < NR; i++) begin
         req_pkt[i*PW +: PW] = pk[i];
         req_len[i*32 +: 32] = ln[i];
      end
      req_valid = v;
   endtask

   task automatic wait_idle(input int req_cyc);
      int k;
      for (k = 0; k < 60; k++) begin
         if (!sched_busy) break;
         @(negedge clock);
      end
      if (k == 60) begin
         n_cmp++;
         n_bad++;
         $display("FAIL idle_timeout got=busy required=idle by cyc %0d", req_cyc);
      end else begin
         chk("idle_cycle", 128'(cyc), 128'(req_cyc));
      end
   endtask

   // mode 0: tx_busy rises after d cycles and stays b cycles; mode 1: tx_busy never rises.
   task automatic txn(input logic [NR-1:0] v, input int mode, input int d, input int b,
                      input logic [NR-1:0] glitch);
      int c, w, end_c;
      bit ok;
      logic [127:0] t;
      @(negedge clock);
      drive_reqs(v);
      c = cyc;
      w = pick(v);
`ifndef TX_SCHED_STRICT_PRIO_EN
      rr_m = (w + 1) % NR;
`endif
      ok = (ln[w] >= 8) && (ln[w] <= PW);
      if (!ok) begin
         exp_q.push_back(mk(c + 1, w, 1, 0, 1, 0));
         end_c = c + 1;
      end else begin
         exp_q.push_back(mk(c + 1, w, 1, 0, 0, 1));
         if (mode == 1) begin
            end_c = c + 1 + STO;
            exp_q.push_back(mk(end_c, w, 0, 0, 1, 0));
         end else begin
            end_c = c + 1 + d + b;
            exp_q.push_back(mk(end_c, w, 0, 1, 0, 0));
         end
      end
      @(negedge clock);
      req_valid = '0;
      t = {$urandom, $urandom, $urandom, $urandom};
      req_pkt[PW-1:0] = t[PW-1:0];
      req_len[31:0]   = $urandom;
      if (ok && mode == 0) begin
         repeat (d) @(negedge clock);
         tx_busy = 1'b1;
         repeat (b) @(negedge clock);
         tx_busy = 1'b0;
      end
      while (cyc < end_c) @(negedge clock);
      if (glitch != '0) begin
         @(negedge clock);
         req_valid = glitch;
         tx_busy   = 1'b1;
         repeat (IPG - 1) @(negedge clock);
         req_valid = '0;
         tx_busy   = 1'b0;
      end
      wait_idle(end_c + 1 + IPG);
   endtask

   task automatic rand_reqs();
      logic [127:0] t;
      int sel;
      for (int i = 0; i < NR; i++) begin
         t     = {$urandom, $urandom, $urandom, $urandom};
         pk[i] = t[PW-1:0];
         sel   = $urandom_range(0, 9);
         if (sel == 0)      ln[i] = $urandom_range(0, 7);
         else if (sel == 1) ln[i] = $urandom_range(PW + 1, 300);
         else if (sel == 2) ln[i] = $urandom;
         else               ln[i] = $urandom_range(8, PW);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] z;
      z = '0;
      repeat (3) @(negedge clock);
      chk("reset_outputs", {req_ack, req_done, req_err, pkt_ready, sched_busy, pkt_len},
          128'd0);
      chk("reset_pkt_in", 128'(pkt_in), z);
      reset_n = 1'b1;

      // Single request, 19-bit packet, 30 busy cycles.
      rand_reqs();
      pk[0] = PW'(19'b0100_0000101_11100001);
      ln[0] = 32'd19;
      txn(3'b001, 0, 1, 30, '0);

      // Start timeout, then a normal grant.
      rand_reqs();
      ln[1] = 32'd24;
      txn(3'b010, 1, 0, 0, '0);
      rand_reqs();
      ln[2] = 32'd40;
      txn(3'b100, 0, 3, 5, '0);

      // Length bounds: 0, 101 rejected; 8 and PW accepted.
      rand_reqs();
      ln[0] = 32'd0;   txn(3'b001, 0, 1, 1, '0);
      ln[0] = 32'd101; txn(3'b001, 0, 1, 1, '0);
      ln[0] = 32'd8;   txn(3'b001, 0, 2, 2, '0);
      ln[0] = 32'd100; txn(3'b001, 0, 2, 2, '0);

      // Request during gap is not sampled; reasserted in idle it is granted.
      rand_reqs();
      ln[0] = 32'd16; ln[2] = 32'd16;
      txn(3'b001, 0, 1, 4, 3'b100);
      txn(3'b100, 0, 1, 4, '0);

      // Reset while sending: winner 1 leaves the model pointer at 2 before reset.
      rand_reqs();
      ln[1] = 32'd32;
      @(negedge clock);
      drive_reqs(3'b010);
      exp_q.push_back(mk(cyc + 1, 1, 1, 0, 0, 1));
      @(negedge clock);
      req_valid = '0;
      tx_busy   = 1'b1;
      repeat (3) @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("midreset_outputs", {req_ack, req_done, req_err, pkt_ready, sched_busy, pkt_len},
          128'd0);
      chk("midreset_pkt_in", 128'(pkt_in), z);
      tx_busy = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      rr_m = 0;
      rand_reqs();
      ln[1] = 32'd20; ln[2] = 32'd20;
      txn(3'b110, 0, 1, 3, '0);

      // All three held: rotation.
      rand_reqs();
      for (int i = 0; i < NR; i++) ln[i] = 32'd50;
      for (int k = 0; k < 4; k++) txn(3'b111, 0, 1, 10, '0);

      // Randomised traffic.
      for (int k = 0; k < 40; k++) begin
         logic [NR-1:0] v, g;
         int mode;
         rand_reqs();
         v    = NR'($urandom_range(1, (1 << NR) - 1));
         mode = ($urandom_range(0, 6) == 0) ? 1 : 0;
         g    = ($urandom_range(0, 2) == 0) ? NR'($urandom_range(1, (1 << NR) - 1)) : '0;
         txn(v, mode, $urandom_range(1, 8), $urandom_range(1, 12), g);
      end

      repeat (3) @(negedge clock);
      chk("queue_drained", 128'(exp_q.size()), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
